// File: rtl/cond_match_unit.sv
// Multi-channel condition matcher: per-channel masked-equal / less-than / greater-or-equal
// compare of each valid sample, registered hit flags, first-hit encoder and saturating counters.
module cond_match_unit #(
    parameter int WIDTH     = 8,
    parameter int CHANNELS  = 4,
    parameter int CNT_WIDTH = 16,
    parameter int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_valid,
    input  logic [WIDTH-1:0]              i_data,
    input  logic                          i_cfg_we,
    input  logic [CH_W-1:0]               i_cfg_ch,
    input  logic [1:0]                    i_cfg_mode,
    input  logic [WIDTH-1:0]              i_cfg_value,
    input  logic [WIDTH-1:0]              i_cfg_mask,
    input  logic                          i_clear,
    output logic [CHANNELS-1:0]           o_hit,
    output logic                          o_any_hit,
    output logic [CH_W-1:0]               o_first_ch,
    output logic [CHANNELS*CNT_WIDTH-1:0] o_count,
    output logic [CHANNELS-1:0]           o_sat
);

    localparam logic [1:0] MODE_OFF = 2'b00;
    localparam logic [1:0] MODE_EQ  = 2'b01;
    localparam logic [1:0] MODE_LT  = 2'b10;
    localparam logic [1:0] MODE_GE  = 2'b11;

    function automatic logic match_fn(
        input logic [1:0]       mode,
        input logic [WIDTH-1:0] value,
        input logic [WIDTH-1:0] mask,
        input logic [WIDTH-1:0] data
    );
        logic m;
        m = 1'b0;
        case (mode)
            MODE_OFF: m = 1'b0;
            MODE_EQ:  m = (((data ^ value) & ~mask) == '0);
            MODE_LT:  m = (data < value);
            MODE_GE:  m = (data >= value);
            default:  m = 1'b0;
        endcase
        return m;
    endfunction

    logic [CHANNELS-1:0] hit_next;
    logic [CHANNELS-1:0] hit_reg;
    logic                any_hit_reg;
    logic [CH_W-1:0]     first_ch_next;
    logic [CH_W-1:0]     first_ch_reg;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [1:0]           mode_reg;
            logic [WIDTH-1:0]     value_reg;
            logic [WIDTH-1:0]     mask_reg;
            logic [CNT_WIDTH-1:0] count_reg;
            logic [CNT_WIDTH-1:0] count_next;
            logic                 sat_reg;
            logic                 sat_next;
            logic                 cfg_sel;

            // Out-of-range channel indices never compare equal to any gi, so they are dropped.
            assign cfg_sel = i_cfg_we && (i_cfg_ch == CH_W'(gi));

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    mode_reg  <= MODE_OFF;
                    value_reg <= '0;
                    mask_reg  <= '0;
                end else if (cfg_sel) begin
                    mode_reg  <= i_cfg_mode;
                    value_reg <= i_cfg_value;
                    mask_reg  <= i_cfg_mask;
                end
            end

            // Sample is compared against the config as it stands before any same-cycle write.
            assign hit_next[gi] = i_valid && match_fn(mode_reg, value_reg, mask_reg, i_data);

            always_comb begin
                count_next = count_reg;
                sat_next   = sat_reg;
                if (i_clear) begin
                    count_next = '0;
                    sat_next   = 1'b0;
                end else begin
                    if (hit_next[gi] && (count_reg != '1)) begin
                        count_next = count_reg + CNT_WIDTH'(1);
                    end
                    if (count_next == '1) begin
                        sat_next = 1'b1;
                    end
                end
            end

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    count_reg <= '0;
                    sat_reg   <= 1'b0;
                end else begin
                    count_reg <= count_next;
                    sat_reg   <= sat_next;
                end
            end

            assign o_count[gi*CNT_WIDTH +: CNT_WIDTH] = count_reg;
            assign o_sat[gi]                          = sat_reg;
        end
    endgenerate

    // Scan downward so the lowest hitting index is the last one written.
    always_comb begin
        first_ch_next = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (hit_next[i]) begin
                first_ch_next = CH_W'(i);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hit_reg      <= '0;
            any_hit_reg  <= 1'b0;
            first_ch_reg <= '0;
        end else begin
            hit_reg      <= hit_next;
            any_hit_reg  <= |hit_next;
            first_ch_reg <= first_ch_next;
        end
    end

    assign o_hit      = hit_reg;
    assign o_any_hit  = any_hit_reg;
    assign o_first_ch = first_ch_reg;

endmodule
